// File: rtl/even_odd_pkg.sv
// Shared types and constants for the even/odd sequence generator.
package even_odd_pkg;

   // Generator FSM states
   typedef enum logic [1:0] {
      EO_IDLE = 2'd0,
      EO_RUN  = 2'd1,
      EO_DONE = 2'd2
   } eo_state_t;

   localparam logic        MODE_EVEN = 1'b0;
   localparam logic        MODE_ODD  = 1'b1;
   localparam int unsigned EO_STEP   = 2;

endpackage

// File: rtl/eo_parity_check.sv
// Combinational parity classifier used by the optional self-check.
module eo_parity_check #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] num,
   output logic             is_even
);

   // Only bit 0 decides parity; the upper bits are intentionally ignored.
   logic w_unused_upper;

   assign w_unused_upper = ^num;
   assign is_even        = ~num[0];

endmodule

// File: rtl/even_odd_seq_gen.sv
// Even/odd number stream producer with valid/ready output.
// Optional self-check enabled by defining EVEN_ODD_SELFCHK_EN (adds chk_err).
module even_odd_seq_gen #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] start_val,
   input  logic [WIDTH-1:0] count,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_num,
   output logic             out_last,
   output logic             busy,
   output logic             done
`ifdef EVEN_ODD_SELFCHK_EN
  ,output logic             chk_err
`endif
);

   import even_odd_pkg::*;

   eo_state_t        r_state;
   logic             r_mode;
   logic [WIDTH-1:0] r_rem;

   logic             w_hs;
   logic [WIDTH-1:0] w_first;

   assign w_hs    = out_valid && out_ready;
   // First value: start_val if it already has the requested parity, else the next one up.
   assign w_first = (start_val[0] == mode) ? start_val : start_val + WIDTH'(1);

   // Generator FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= EO_IDLE;
         r_mode    <= MODE_EVEN;
         r_rem     <= '0;
         out_valid <= 1'b0;
         out_num   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (r_state)
            EO_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (count != '0) begin
                     r_state   <= EO_RUN;
                     r_mode    <= mode;
                     r_rem     <= count;
                     out_num   <= w_first;
                     out_valid <= 1'b1;
                     out_last  <= (count == WIDTH'(1));
                     busy      <= 1'b1;
                  end else begin
                     r_state <= EO_DONE;
                     done    <= 1'b1;
                  end
               end
            end
            EO_RUN: begin
               if (w_hs) begin
                  if (r_rem == WIDTH'(1)) begin
                     r_state   <= EO_DONE;
                     r_rem     <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     out_num  <= out_num + WIDTH'(EO_STEP);
                     r_rem    <= r_rem - WIDTH'(1);
                     out_last <= (r_rem == WIDTH'(2));
                  end
               end
            end
            EO_DONE: begin
               done    <= 1'b0;
               r_state <= EO_IDLE;
            end
            default: begin
               r_state   <= EO_IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

`ifdef EVEN_ODD_SELFCHK_EN
   logic w_is_even;

   eo_parity_check #(.WIDTH(WIDTH)) u_parity_check (
      .num     (out_num),
      .is_even (w_is_even)
   );

   // Flag a presented value whose parity disagrees with the captured mode
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_err <= 1'b0;
      end else begin
         chk_err <= out_valid && (w_is_even == (r_mode == MODE_ODD));
      end
   end
`else
   logic w_unused_mode;

   assign w_unused_mode = r_mode;
`endif

endmodule
